// File: rtl/noc_params.sv
// noc_params
// Shared NoC sizing constants and the output-port direction type.
// PORT_NUM  : number of router ports (local plus four mesh directions)
// VC_NUM    : virtual channels per input port
// VC_SIZE   : width of a VC index
// PORT_SIZE : width of a port index / port_t
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    // Router output directions; codes at or above PORT_NUM are not legal targets.
    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter
// Combinational round-robin arbiter with a registered priority pointer.
// Ports:
//   clk       : clock, pointer updates on rising edge
//   rst       : synchronous active-high reset, pointer loads 0
//   requests  : one request bit per agent
//   update_en : advance the pointer past the current winner this cycle
//   grant     : one-hot grant, all zero when nothing is requested
module round_robin_arbiter #(
    parameter int AGENTS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] requests,
    input  logic                  update_en,
    output logic [AGENTS_NUM-1:0] grant
);

    localparam int PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

    logic [PTR_W-1:0] pointer;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] sel;
    logic             found;
    int               idx;

    // Scan agents starting at the pointer, wrapping around; the first
    // requester met in that order wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        sel    = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < AGENTS_NUM; i++) begin
            idx = int'(pointer) + i;
            if (idx >= AGENTS_NUM) begin
                idx = idx - AGENTS_NUM;
            end
            sel = PTR_W'(idx);
            if (!found && requests[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                winner     = sel;
            end
        end
    end

    // The pointer moves to the agent just after the winner, but only when the
    // grant was actually consumed downstream; otherwise priority is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pointer <= '0;
        end else if (update_en && found) begin
            if (winner == PTR_W'(AGENTS_NUM - 1)) begin
                pointer <= '0;
            end else begin
                pointer <= winner + 1'b1;
            end
        end
    end

endmodule

// File: rtl/separable_switch_allocator.sv
// separable_switch_allocator
// Input-first separable switch allocator for a PORT_NUM-port, VC_NUM-VC router.
// Stage 1 picks one candidate VC per input port, stage 2 picks one input port
// per output port. Grants are combinational (same cycle as the request).
// Ports (out_port_i / vc_sel_o / valid_sel_o form the input-block side,
// xb_sel_o / xb_valid_o drive the crossbar):
//   clk         : clock
//   rst         : synchronous active-high reset; forces all outputs to 0
//   request_i   : per input port and VC, head flit eligible for the switch
//   out_port_i  : per input port and VC, requested output direction
//   vc_sel_o    : per input port, granted VC
//   valid_sel_o : per input port, a grant was given
//   xb_sel_o    : per output port, winning input port index
//   xb_valid_o  : per output port, a flit crosses this cycle
module separable_switch_allocator
    import noc_params::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]     request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]     out_port_i,
    output logic  [PORT_NUM-1:0][VC_SIZE-1:0]    vc_sel_o,
    output logic  [PORT_NUM-1:0]                 valid_sel_o,
    output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]  xb_sel_o,
    output logic  [PORT_NUM-1:0]                 xb_valid_o
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]    vc_req;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]    vc_grant;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
    logic  [PORT_NUM-1:0]                cand_valid;
    port_t [PORT_NUM-1:0]                cand_port;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]  out_req;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]  out_grant;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel;
    logic  [PORT_NUM-1:0]                valid_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel;
    logic  [PORT_NUM-1:0]                xb_valid;

    // A VC pointing at a nonexistent output is simply not a requester, so it
    // can neither win stage 1 nor disturb any pointer.
    always_comb begin
        vc_req = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                vc_req[p][v] = request_i[p][v] &&
                               (out_port_i[p][v] < PORT_SIZE'(PORT_NUM));
            end
        end
    end

    // Stage 1 arbiters: one per input port over its VCs. Pointer advances only
    // when the port's candidate also won its output in stage 2.
    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_vc_arb
        round_robin_arbiter #(
            .AGENTS_NUM (VC_NUM)
        ) vc_arb (
            .clk       (clk),
            .rst       (rst),
            .requests  (vc_req[gp]),
            .update_en (valid_sel[gp]),
            .grant     (vc_grant[gp])
        );
    end

    // Turn each one-hot stage-1 grant into a VC index plus the output port
    // that VC's head flit wants.
    always_comb begin
        cand_vc    = '0;
        cand_valid = '0;
        cand_port  = {PORT_NUM{LOCAL}};
        for (int p = 0; p < PORT_NUM; p++) begin
            cand_valid[p] = |vc_grant[p];
            for (int v = 0; v < VC_NUM; v++) begin
                if (vc_grant[p][v]) begin
                    cand_vc[p]   = VC_SIZE'(v);
                    cand_port[p] = out_port_i[p][v];
                end
            end
        end
    end

    // Stage 2 request matrix: output o sees input p only if p's single
    // candidate targets o, which guarantees at most one grant per input.
    always_comb begin
        out_req = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                out_req[o][p] = cand_valid[p] &&
                                (cand_port[p] == PORT_SIZE'(o));
            end
        end
    end

    for (genvar go = 0; go < PORT_NUM; go++) begin : g_out_arb
        round_robin_arbiter #(
            .AGENTS_NUM (PORT_NUM)
        ) out_arb (
            .clk       (clk),
            .rst       (rst),
            .requests  (out_req[go]),
            .update_en (xb_valid[go]),
            .grant     (out_grant[go])
        );
    end

    // Fold the stage-2 grant matrix back into per-output crossbar selects and
    // per-input grant flags; unused selects stay 0.
    always_comb begin
        xb_sel    = '0;
        xb_valid  = '0;
        valid_sel = '0;
        vc_sel    = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            xb_valid[o] = |out_grant[o];
            for (int p = 0; p < PORT_NUM; p++) begin
                if (out_grant[o][p]) begin
                    xb_sel[o]    = PORT_SIZE'(p);
                    valid_sel[p] = 1'b1;
                end
            end
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            if (valid_sel[p]) begin
                vc_sel[p] = cand_vc[p];
            end
        end
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    assign vc_sel_o    = rst ? '0 : vc_sel;
    assign valid_sel_o = rst ? '0 : valid_sel;
    assign xb_sel_o    = rst ? '0 : xb_sel;
    assign xb_valid_o  = rst ? '0 : xb_valid;

endmodule

// File: tb/tb_separable_switch_allocator.sv
// tb_separable_switch_allocator
// Drives directed scenarios and random traffic into the allocator and compares
// every output against a behavioural model of the allocation rules.
module tb_separable_switch_allocator;
    import noc_params::*;

    logic                                clk = 1'b0;
    logic                                rst;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]    request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]    out_port;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel;
    logic  [PORT_NUM-1:0]                valid_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel;
    logic  [PORT_NUM-1:0]                xb_valid;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]    rq;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]    tg;

    int inPtr[PORT_NUM];
    int outPtr[PORT_NUM];
    int checks = 0;
    int errors = 0;

    separable_switch_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .request_i   (request),
        .out_port_i  (out_port),
        .vc_sel_o    (vc_sel),
        .valid_sel_o (valid_sel),
        .xb_sel_o    (xb_sel),
        .xb_valid_o  (xb_valid)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStaging();
        rq = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                tg[p][v] = LOCAL;
            end
        end
    endtask

    // One cycle: drive staged inputs at the falling edge, predict the grants
    // from the allocation rules, compare, then advance the model pointers the
    // way the next rising edge should.
    task automatic applyStimulus(input logic rstVal);
        int cand[PORT_NUM];
        int winner[PORT_NUM];
        int v;
        int p;
        logic [PORT_NUM-1:0][VC_SIZE-1:0]   expVc;
        logic [PORT_NUM-1:0]                expValid;
        logic [PORT_NUM-1:0][PORT_SIZE-1:0] expXbSel;
        logic [PORT_NUM-1:0]                expXbValid;

        @(negedge clk);
        rst      = rstVal;
        request  = rq;
        out_port = tg;
        #1;

        expVc = '0; expValid = '0; expXbSel = '0; expXbValid = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            cand[i]   = -1;
            winner[i] = -1;
        end
        if (!rstVal) begin
            for (int q = 0; q < PORT_NUM; q++) begin
                for (int k = 0; k < VC_NUM; k++) begin
                    v = (inPtr[q] + k) % VC_NUM;
                    if (cand[q] < 0 && rq[q][v] && int'(tg[q][v]) < PORT_NUM) begin
                        cand[q] = v;
                    end
                end
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int k = 0; k < PORT_NUM; k++) begin
                    p = (outPtr[o] + k) % PORT_NUM;
                    if (winner[o] < 0 && cand[p] >= 0 && int'(tg[p][cand[p]]) == o) begin
                        winner[o]     = p;
                        expXbValid[o] = 1'b1;
                        expXbSel[o]   = PORT_SIZE'(p);
                        expValid[p]   = 1'b1;
                        expVc[p]      = VC_SIZE'(cand[p]);
                    end
                end
            end
        end

        checkOutput("valid_sel", 32'(valid_sel), 32'(expValid));
        checkOutput("vc_sel",    32'(vc_sel),    32'(expVc));
        checkOutput("xb_valid",  32'(xb_valid),  32'(expXbValid));
        checkOutput("xb_sel",    32'(xb_sel),    32'(expXbSel));

        for (int i = 0; i < PORT_NUM; i++) begin
            if (rstVal) begin
                inPtr[i]  = 0;
                outPtr[i] = 0;
            end else begin
                if (expValid[i]) inPtr[i] = (cand[i] + 1) % VC_NUM;
                if (winner[i] >= 0) outPtr[i] = (winner[i] + 1) % PORT_NUM;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clearStaging();
        request  = rq;
        out_port = tg;
        for (int i = 0; i < PORT_NUM; i++) begin
            inPtr[i]  = 0;
            outPtr[i] = 0;
        end

        // Reset state, with requests present to show outputs stay quiet.
        rq[0][0] = 1'b1; tg[0][0] = NORTH;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("reset_quiet", 32'({valid_sel, xb_valid}), 32'd0);

        // Single request: port 0 VC1 to EAST.
        clearStaging();
        rq[0][1] = 1'b1; tg[0][1] = EAST;
        applyStimulus(1'b0);
        checkOutput("single_valid", 32'(valid_sel[0]), 32'd1);
        checkOutput("single_vc",    32'(vc_sel[0]),    32'd1);
        checkOutput("single_xbsel", 32'(xb_sel[4]),    32'd0);
        checkOutput("single_xbval", 32'(xb_valid[4]),  32'd1);

        // Output conflict on LOCAL: ports 1,2,3 served in order.
        clearStaging();
        applyStimulus(1'b1);
        rq[1][0] = 1'b1; rq[2][0] = 1'b1; rq[3][0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0);
            checkOutput("conflict_xbsel", 32'(xb_sel[0]), 32'(c));
            checkOutput("conflict_onehot", 32'(valid_sel), 32'(1 << c));
        end

        // Reset mid-run after two conflict cycles; first post-reset grant is port 1.
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("midrst_quiet", 32'({valid_sel, xb_valid, xb_sel, vc_sel}), 32'd0);
        applyStimulus(1'b0);
        checkOutput("midrst_after", 32'(xb_sel[0]), 32'd1);

        // VC fairness: port 2 both VCs to NORTH alternate 0,1,0,1.
        clearStaging();
        applyStimulus(1'b1);
        rq[2][0] = 1'b1; tg[2][0] = NORTH;
        rq[2][1] = 1'b1; tg[2][1] = NORTH;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0);
            checkOutput("vc_fair", 32'(vc_sel[2]), 32'(c % 2));
        end

        // Input-first loss: port 1 loses NORTH in cycle 1, both served in cycle 2.
        clearStaging();
        applyStimulus(1'b1);
        rq[0][0] = 1'b1; tg[0][0] = NORTH;
        rq[0][1] = 1'b1; tg[0][1] = SOUTH;
        rq[1][0] = 1'b1; tg[1][0] = NORTH;
        applyStimulus(1'b0);
        checkOutput("loss_c1_valid", 32'(valid_sel[1:0]), 32'b01);
        checkOutput("loss_c1_south", 32'(xb_valid[2]),    32'd0);
        applyStimulus(1'b0);
        checkOutput("loss_c2_valid", 32'(valid_sel[1:0]), 32'b11);
        checkOutput("loss_c2_vc0",   32'(vc_sel[0]),      32'd1);

        // Illegal target: no grant, pointer untouched so VC0 still goes first.
        clearStaging();
        applyStimulus(1'b1);
        rq[3][0] = 1'b1; tg[3][0] = port_t'(3'd7);
        applyStimulus(1'b0);
        checkOutput("illegal_none", 32'({valid_sel, xb_valid}), 32'd0);
        rq[3][0] = 1'b1; tg[3][0] = WEST;
        rq[3][1] = 1'b1; tg[3][1] = WEST;
        applyStimulus(1'b0);
        checkOutput("illegal_after_vc", 32'(vc_sel[3]), 32'd0);

        // Random traffic with occasional resets and illegal targets.
        for (int n = 0; n < 500; n++) begin
            for (int q = 0; q < PORT_NUM; q++) begin
                for (int k = 0; k < VC_NUM; k++) begin
                    rq[q][k] = ($urandom_range(0, 2) != 0);
                    if ($urandom_range(0, 7) == 7) begin
                        tg[q][k] = port_t'(3'($urandom_range(5, 7)));
                    end else begin
                        tg[q][k] = port_t'(3'($urandom_range(0, 4)));
                    end
                end
            end
            applyStimulus($urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/separable_switch_allocator.md
SEPARABLE_SWITCH_ALLOCATOR -- requirements
Module: separable_switch_allocator

Interface
REQ-001 Module SHALL have no module parameters; sizes SHALL come from noc_params: PORT_NUM (5), VC_NUM (2), VC_SIZE = $clog2(VC_NUM), PORT_SIZE = $clog2(PORT_NUM).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 request_i  input  [PORT_NUM][VC_NUM] x 1  VC v of input port p holds an eligible head flit (VC allocated, downstream credit present).
REQ-005 out_port_i  input  [PORT_NUM][VC_NUM] x port_t  output port targeted by that VC's head flit.
REQ-006 vc_sel_o  output  [PORT_NUM] x VC_SIZE  granted VC per input port, to input block.
REQ-007 valid_sel_o  output  [PORT_NUM] x 1  input port p received a grant this cycle.
REQ-008 xb_sel_o  output  [PORT_NUM] x PORT_SIZE  per output port, winning input port index, to crossbar.
REQ-009 xb_valid_o  output  [PORT_NUM] x 1  output port o carries a flit this cycle.

Function
REQ-010 Allocation SHALL be separable input-first: stage 1 picks one candidate VC per input port, stage 2 picks one input port per output port.
REQ-011 Stage 1 SHALL round-robin among VCs of port p with request_i=1, starting at that port's input pointer; winner c_p targets out_port_i[p][c_p].
REQ-012 Stage 2 SHALL round-robin among input ports whose candidate targets o, starting at output o's pointer.
REQ-013 Grants SHALL be combinational, zero latency: same cycle, valid_sel_o[p]=1, vc_sel_o[p]=c_p, xb_sel_o[o]=p, xb_valid_o[o]=1.
REQ-014 At most one grant per input port and per output port per cycle; vc_sel_o and xb_sel_o SHALL agree.
REQ-015 Input pointer of p SHALL update only when valid_sel_o[p]=1, to (c_p+1) mod VC_NUM; otherwise hold.
REQ-016 Output pointer of o SHALL update only when xb_valid_o[o]=1, to (p+1) mod PORT_NUM; otherwise hold.
REQ-017 Pointer wrap: VC_NUM-1 -> 0, PORT_NUM-1 -> 0.
REQ-018 out_port_i value >= PORT_NUM SHALL be treated as no request; no grant, no pointer change.
REQ-019 Ungranted outputs SHALL be 0 (vc_sel_o, xb_sel_o zero when respective valid is 0).
REQ-020 No requests: all valids 0, all pointers hold.

Reset
REQ-021 While rst=1, all outputs SHALL be 0 regardless of inputs.
REQ-022 On rst, all input and output pointers SHALL load 0.
REQ-023 Reset mid-operation SHALL discard arbitration history; first cycle after deassertion behaves as post-power-up.

Structure
REQ-024 port_t, PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE SHALL reside in noc_params; no new package types.
REQ-025 One sub-module round_robin_arbiter #(AGENTS_NUM) (clk, rst, requests, update_en, one-hot grant, registered pointer) SHALL be instantiated PORT_NUM times with AGENTS_NUM=VC_NUM and PORT_NUM times with AGENTS_NUM=PORT_NUM.
REQ-026 Port groups SHALL map onto the switch_allocator modport of input_block2switch_allocator (out_port, vc_sel, valid_sel).

Verification
REQ-027 Single: port 0 VC1 -> EAST(4) -> same cycle valid_sel_o[0]=1, vc_sel_o[0]=1, xb_sel_o[4]=0, xb_valid_o[4]=1.
REQ-028 Output conflict: ports 1,2,3 VC0 -> LOCAL held 3 cycles after reset -> grants port 1, 2, 3 in order; one xb_valid_o[0] per cycle.
REQ-029 VC fairness: port 2 VC0 and VC1 both -> NORTH held 4 cycles -> vc_sel_o[2] = 0,1,0,1.
REQ-030 Input-first loss: port 0 VC0->NORTH, VC1->SOUTH; port 1 VC0->NORTH -> cycle 1 port 0 VC0 wins NORTH, port 1 none, SOUTH idle; cycle 2 port 0 VC1->SOUTH and port 1->NORTH both granted.
REQ-031 Reset mid-run: after REQ-028 cycle 2, rst high 1 cycle with requests held -> outputs 0 during rst; next cycle port 1 granted.
REQ-032 Illegal target: port 3 VC0 out_port_i=7 -> no grant, pointers unchanged (confirmed by subsequent legal request ordering).
